alu_sequencer: RTL and testbench

Command front-end and initiator for the fp8 (e4m3) ALU. Accepts one operation at a time over a valid/ready request channel and drives operands and `alu_ctrl` into the ALU. It waits for the ALU's registered `is_output_valid`, guarded by a timeout, and returns the result over a valid/ready response channel. The block sits between the instruction/issue logic and the `alu` instance and owns all handshake and sequencing toward it.

---
 rtl/alu_sequencer_if.sv | 48 ++++
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - handshake bundle between issue logic, alu_sequencer and the fp8 ALU
//
// Purpose: groups the request, response, ALU-side and status signals of
// alu_sequencer so they travel as one port.
// Modports:
//   slave  - the sequencer's view (consumes requests and ALU results,
//            produces responses, ALU operands/control and status)
//   master - the environment's view (issue logic + ALU + response consumer)
// Signals:
//   req_valid/req_ready/req_op[1:0]/req_a[7:0]/req_b[7:0] - request channel
//   rsp_valid/rsp_ready/rsp_data[7:0]/rsp_err             - response channel
//   alu_a[7:0]/alu_b[7:0]/alu_ctrl[3:0]/alu_y[7:0]/alu_valid - ALU side
//   busy, stat_ops[15:0], stat_errs[7:0]                  - status

interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_y;
  logic       alu_valid;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  logic        busy;
  logic [15:0] stat_ops;
  logic [7:0]  stat_errs;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_y, alu_valid, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_err,
           busy, stat_ops, stat_errs
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_y, alu_valid, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_err,
           busy, stat_ops, stat_errs
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - one-op-at-a-time command front-end for the fp8 (e4m3) ALU
//
// Purpose: accepts one add/mul request, drives registered operands and
// alu_ctrl into the ALU, waits for the ALU's registered valid under a
// timeout and returns the result (or an error) on the response channel.
// Ports:
//   clock  - single clock, posedge
//   reset  - synchronous, active-high
//   bus    - alu_sequencer_if.slave (request, response, ALU side, status)
// Parameters:
//   TIMEOUT - WAIT cycles allowed before the op is abandoned (2..255)
// Optional feature macro: ALU_SEQ_STATS_EN builds the stat_ops/stat_errs
// counters; without it both status ports are tied to 0.
// All outputs are registered.

module alu_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic            clock,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       req_ready_q;
  logic       busy_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_ctrl_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;

  // 4'b0000 doubles as the "illegal op" marker.
  function automatic logic [3:0] op_to_ctrl(input logic [1:0] op);
    case (op)
      2'd0:    op_to_ctrl = 4'b0001;
      2'd1:    op_to_ctrl = 4'b0010;
      default: op_to_ctrl = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 8'd0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      alu_ctrl_q  <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            alu_a_q     <= bus.req_a;
            alu_b_q     <= bus.req_b;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            wait_cnt_q  <= 8'd0;
            if (op_to_ctrl(bus.req_op) != 4'd0) begin
              alu_ctrl_q <= op_to_ctrl(bus.req_op);
              state_q    <= S_WAIT;
            end else begin
              // Illegal op: answer with an error without touching the ALU.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 8'd0;
              state_q     <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          // On the first WAIT cycle alu_valid still reflects alu_ctrl=0
          // from before the issue, so it cannot belong to this op.
          // A capture on the last allowed cycle beats the timeout.
          if ((wait_cnt_q != 8'd0) && bus.alu_valid) begin
            rsp_data_q  <= bus.alu_y;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            alu_ctrl_q  <= 4'd0;
            state_q     <= S_RESP;
          end else if (wait_cnt_q == LAST_WAIT) begin
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            alu_ctrl_q  <= 4'd0;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        S_RESP: begin
          // Holding alu_ctrl=0 here for at least one cycle clears the ALU's
          // valid register before the next op can be issued.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          alu_ctrl_q  <= 4'd0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops_q;
  logic [15:0] stat_ops_d;
  logic [7:0]  stat_errs_q;
  logic [7:0]  stat_errs_d;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_q & bus.rsp_ready;

  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    if (rsp_hs) begin
      stat_ops_d = stat_ops_q + 16'd1;
      if (rsp_err_q && (stat_errs_q != 8'hFF)) begin
        stat_errs_d = stat_errs_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ops_q  <= 16'd0;
      stat_errs_q <= 8'd0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign bus.stat_ops  = stat_ops_q;
  assign bus.stat_errs = stat_errs_q;
`else
  assign bus.stat_ops  = 16'd0;
  assign bus.stat_errs = 8'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
//
// Purpose: drives hand-picked requests through alu_sequencer against a
// 1-cycle registered ALU stub and checks latency, data, error and status.
// Ports: none (top-level bench).

module tb_alu_sequencer;

  localparam int unsigned TB_TIMEOUT = 4;
`ifdef ALU_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock;
  logic reset;

  alu_sequencer_if bus ();

  alu_sequencer #(
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU stub: registered, result one cycle after a nonzero alu_ctrl.
  logic [7:0] stub_result;
  logic       stub_never;
  logic       stale_arm;

  always @(posedge clock) begin
    if (reset) begin
      bus.alu_valid <= 1'b0;
      bus.alu_y     <= 8'd0;
    end else if (stub_never) begin
      bus.alu_valid <= 1'b0;
    end else if (bus.alu_ctrl != 4'd0) begin
      bus.alu_valid <= 1'b1;
      bus.alu_y     <= stub_result;
    end else if (stale_arm) begin
      bus.alu_valid <= 1'b1;
      bus.alu_y     <= 8'hFF;
    end else begin
      bus.alu_valid <= 1'b0;
    end
  end

  int n_checks;
  int n_errs;
  int exp_ops;
  int exp_errs;
  int cyc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request in IDLE; returns in cycle 1 (first cycle after accept).
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Counts cycles from cycle 1 until rsp_valid is seen, bounded by limit.
  task automatic wait_rsp(input int limit, output int n);
    n = 1;
    while (!bus.rsp_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic handshake(input logic err_exp);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_ops++;
    if (err_exp) exp_errs++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_ops"},  bus.stat_ops,         STATS ? 16'(exp_ops)  : 16'd0);
    check({tag, "_stat_errs"}, {8'd0, bus.stat_errs}, STATS ? 16'(exp_errs) : 16'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errs        = 0;
    exp_ops       = 0;
    exp_errs      = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a     = 8'd0;
    bus.req_b     = 8'd0;
    bus.rsp_ready = 1'b0;
    stub_result   = 8'd0;
    stub_never    = 1'b0;
    stale_arm     = 1'b0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst_req_ready", {15'd0, bus.req_ready}, 16'd1);
    check("rst_busy",      {15'd0, bus.busy},      16'd0);
    check("rst_alu_a",     {8'd0, bus.alu_a},      16'd0);
    check("rst_alu_b",     {8'd0, bus.alu_b},      16'd0);
    check("rst_alu_ctrl",  {12'd0, bus.alu_ctrl},  16'd0);
    check("rst_rsp_valid", {15'd0, bus.rsp_valid}, 16'd0);
    check("rst_rsp_data",  {8'd0, bus.rsp_data},   16'd0);
    check("rst_rsp_err",   {15'd0, bus.rsp_err},   16'd0);
    check_stats("rst");

    // Add: 0x38 + 0x38 -> stub 0x40, response at cycle 3
    stub_result = 8'h40;
    issue(2'd0, 8'h38, 8'h38);
    check("add_ctrl_c1",      {12'd0, bus.alu_ctrl},  16'h0001);
    check("add_alu_a",        {8'd0, bus.alu_a},      16'h0038);
    check("add_alu_b",        {8'd0, bus.alu_b},      16'h0038);
    check("add_req_ready_c1", {15'd0, bus.req_ready}, 16'd0);
    check("add_busy_c1",      {15'd0, bus.busy},      16'd1);
    wait_rsp(20, cyc);
    check("add_latency", 16'(cyc), 16'd3);
    check("add_data",    {8'd0, bus.rsp_data}, 16'h0040);
    check("add_err",     {15'd0, bus.rsp_err}, 16'd0);
    handshake(1'b0);
    check("add_idle_ready", {15'd0, bus.req_ready}, 16'd1);

    // Mul with 5 cycles of backpressure
    stub_result = 8'h48;
    issue(2'd1, 8'h40, 8'h38);
    check("mul_ctrl_c1", {12'd0, bus.alu_ctrl}, 16'h0002);
    wait_rsp(20, cyc);
    check("mul_latency", 16'(cyc), 16'd3);
    for (int i = 0; i < 5; i++) begin
      check("mul_bp_valid",     {15'd0, bus.rsp_valid}, 16'd1);
      check("mul_bp_data",      {8'd0, bus.rsp_data},   16'h0048);
      check("mul_bp_err",       {15'd0, bus.rsp_err},   16'd0);
      check("mul_bp_req_ready", {15'd0, bus.req_ready}, 16'd0);
      check("mul_bp_ctrl",      {12'd0, bus.alu_ctrl},  16'd0);
      step();
    end
    handshake(1'b0);
    check("mul_idle_ready", {15'd0, bus.req_ready}, 16'd1);
    check("mul_idle_busy",  {15'd0, bus.busy},      16'd0);
    check("mul_idle_valid", {15'd0, bus.rsp_valid}, 16'd0);
    check_stats("mul");

    // Stale valid on the first WAIT cycle must be ignored
    stub_result = 8'h44;
    stale_arm   = 1'b1;
    issue(2'd0, 8'h30, 8'h30);
    stale_arm = 1'b0;
    wait_rsp(20, cyc);
    check("stale_latency", 16'(cyc), 16'd3);
    check("stale_data",    {8'd0, bus.rsp_data}, 16'h0044);
    check("stale_err",     {15'd0, bus.rsp_err}, 16'd0);
    handshake(1'b0);

    // Timeout: ALU never answers, response at cycle TIMEOUT+1
    stub_never = 1'b1;
    issue(2'd0, 8'h11, 8'h22);
    wait_rsp(20, cyc);
    check("to_latency", 16'(cyc), 16'(TB_TIMEOUT + 1));
    check("to_err",     {15'd0, bus.rsp_err}, 16'd1);
    check("to_data",    {8'd0, bus.rsp_data}, 16'd0);
    check("to_ctrl",    {12'd0, bus.alu_ctrl}, 16'd0);
    handshake(1'b1);
    stub_never = 1'b0;

    // Illegal op: no ALU issue, error response at cycle 1
    issue(2'd3, 8'h55, 8'h66);
    check("ill_ctrl",  {12'd0, bus.alu_ctrl},  16'd0);
    check("ill_valid", {15'd0, bus.rsp_valid}, 16'd1);
    check("ill_err",   {15'd0, bus.rsp_err},   16'd1);
    check("ill_data",  {8'd0, bus.rsp_data},   16'd0);
    handshake(1'b1);
    check_stats("ill");

    // Reset mid-WAIT drops the op silently
    stub_result = 8'h3C;
    issue(2'd0, 8'h38, 8'h30);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ops  = 0;
    exp_errs = 0;
    check("mrst_busy",      {15'd0, bus.busy},      16'd0);
    check("mrst_ctrl",      {12'd0, bus.alu_ctrl},  16'd0);
    check("mrst_rsp_valid", {15'd0, bus.rsp_valid}, 16'd0);
    check("mrst_req_ready", {15'd0, bus.req_ready}, 16'd1);
    check_stats("mrst");
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mrst_no_rsp", {15'd0, bus.rsp_valid}, 16'd0);
    end
    bus.rsp_ready = 1'b0;

    stub_result = 8'h4C;
    issue(2'd1, 8'h44, 8'h40);
    wait_rsp(20, cyc);
    check("post_latency", 16'(cyc), 16'd3);
    check("post_data",    {8'd0, bus.rsp_data}, 16'h004C);
    check("post_err",     {15'd0, bus.rsp_err}, 16'd0);
    handshake(1'b0);
    check_stats("post");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
